// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage RV32M unit: funct3 codes, FSM states,
// special-case result constants and a conditional-negate helper.
package ex_muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_funct_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [MD_XLEN-1:0] MD_DIVZ_QUO = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] MD_OVF_QUO  = 32'h8000_0000;

    // Two's-complement negate when neg is set (magnitude <-> signed value).
    function automatic logic [MD_XLEN-1:0] md_cneg(input logic [MD_XLEN-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the RV32M datapath: radix-2 shift-add multiply step or
// restoring divide step on unsigned magnitudes, selected by is_div.
module muldiv_step
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] shl_s;
    logic [XLEN:0] diff_s;

    // hi:lo is product-high:multiplier for multiply, remainder:dividend for divide
    always_comb begin
        sum_s  = {1'b0, hi_i} + {1'b0, opnd_i};
        shl_s  = {hi_i, lo_i[XLEN-1]};
        diff_s = shl_s - {1'b0, opnd_i};
        hi_o   = hi_i;
        lo_o   = lo_i;
        if (is_div) begin
            if (!diff_s[XLEN]) begin
                hi_o = diff_s[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shl_s[XLEN-1:0];
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo_i[0]) begin
                hi_o = sum_s[XLEN:1];
                lo_o = {sum_s[0], lo_i[XLEN-1:1]};
            end else begin
                hi_o = {1'b0, hi_i[XLEN-1:1]};
                lo_o = {hi_i[0], lo_i[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M unit for the EX stage: FSM, iteration counter, sign handling
// and result register. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            op_valid,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_req,
    output logic            res_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, result_q, result_d;
    logic [2:0]      funct_q, funct_d;
    logic            neg_q, neg_d;

    logic            a_signed_s, b_signed_s, sa_s, sb_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, hi_n_s, lo_n_s, final_s;
    logic [2*XLEN-1:0] prod_s;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod_s;
    assign fast_prod_s = $signed({a_signed_s & reg1[XLEN-1], reg1})
                       * $signed({b_signed_s & reg2[XLEN-1], reg2});
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (funct_q[2]),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .opnd_i (opnd_q),
        .hi_o   (hi_n_s),
        .lo_o   (lo_n_s)
    );

    // Operand decode: signedness per funct3, magnitudes and special cases
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (md_funct_e'(funct))
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            MD_MULHSU: a_signed_s = 1'b1;
            default:   a_signed_s = 1'b0;
        endcase
        sa_s       = a_signed_s & reg1[XLEN-1];
        sb_s       = b_signed_s & reg2[XLEN-1];
        a_mag_s    = md_cneg(reg1, sa_s);
        b_mag_s    = md_cneg(reg2, sb_s);
        div_zero_s = funct[2] && (reg2 == {XLEN{1'b0}});
        div_ovf_s  = funct[2] && !funct[0] && (reg1 == MD_OVF_QUO) && (reg2 == MD_DIVZ_QUO);
    end

    // Sign-corrected result of the final iteration
    always_comb begin
        prod_s = neg_q ? (~{hi_n_s, lo_n_s} + 64'd1) : {hi_n_s, lo_n_s};
        if (funct_q[2]) begin
            final_s = md_cneg(funct_q[1] ? hi_n_s : lo_n_s, neg_q);
        end else if (funct_q[1:0] == 2'b00) begin
            final_s = prod_s[XLEN-1:0];
        end else begin
            final_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath update; flush beats rdy, rdy low freezes everything
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        funct_d  = funct_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            state_d = MD_IDLE;
        end else if (rdy) begin
            case (state_q)
                MD_IDLE: begin
                    if (op_valid) begin
                        funct_d = funct;
                        count_d = {CW{1'b0}};
                        hi_d    = {XLEN{1'b0}};
                        neg_d   = (funct[2] && funct[1]) ? sa_s : (sa_s ^ sb_s);
                        if (div_zero_s) begin
                            result_d = funct[1] ? reg1 : MD_DIVZ_QUO;
                            state_d  = MD_DONE;
                        end else if (div_ovf_s) begin
                            result_d = funct[1] ? {XLEN{1'b0}} : MD_OVF_QUO;
                            state_d  = MD_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct[2]) begin
                            result_d = (funct[1:0] == 2'b00) ? fast_prod_s[XLEN-1:0]
                                                             : fast_prod_s[2*XLEN-1:XLEN];
                            state_d  = MD_DONE;
`endif
                        end else begin
                            lo_d    = funct[2] ? a_mag_s : b_mag_s;
                            opnd_d  = funct[2] ? b_mag_s : a_mag_s;
                            state_d = MD_BUSY;
                        end
                    end else begin
                        state_d = MD_IDLE;
                    end
                end
                MD_BUSY: begin
                    count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                    hi_d    = hi_n_s;
                    lo_d    = lo_n_s;
                    if (!op_valid) begin
                        state_d = MD_IDLE;
                    end else if (count_q == CNT_LAST) begin
                        result_d = final_s;
                        state_d  = MD_DONE;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end
                MD_DONE: begin
                    if (!hold) begin
                        state_d = MD_IDLE;
                    end else begin
                        state_d = MD_DONE;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            count_q  <= {CW{1'b0}};
            hi_q     <= {XLEN{1'b0}};
            lo_q     <= {XLEN{1'b0}};
            opnd_q   <= {XLEN{1'b0}};
            funct_q  <= 3'd0;
            neg_q    <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            funct_q  <= funct_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign stall_req = op_valid && (state_q != MD_DONE) && !flush;
    assign res_valid = (state_q == MD_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver pushes expected results and
// checks latency/stall timing, a negedge monitor pops on each new result.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, op_valid, flush, hold;
    logic [2:0]  funct;
    logic [31:0] reg1, reg2;
    logic        stall_req, res_valid;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];
    logic        rv_prev  = 1'b0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .op_valid  (op_valid),
        .funct     (funct),
        .reg1      (reg1),
        .reg2      (reg2),
        .flush     (flush),
        .hold      (hold),
        .stall_req (stall_req),
        .res_valid (res_valid),
        .result    (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: each rising res_valid delivers one result to compare
    always @(negedge clk) begin
        if (!rst && res_valid && !rv_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%08h expected none", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
        rv_prev = res_valid;
    end

    // Present one op as ID/EX would, optionally dropping rdy or holding DONE
    task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input int lat,
                         input int rdy_low_at, input int hold_n);
        int  t0, stalls, seen_lat, held;
        logic done;
        exp_q.push_back(e);
        op_valid = 1'b1; funct = f; reg1 = a; reg2 = b;
        t0 = cyc; stalls = 0; seen_lat = -1; held = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            rdy  = !(rdy_low_at >= 0 && k >= rdy_low_at && k < rdy_low_at + 5);
            hold = res_valid && (held < hold_n);
            if (res_valid && held > 0) check({name, "_stable"}, result, e);
            #1;
            if (stall_req) stalls++;
            if (res_valid && seen_lat < 0) seen_lat = cyc - t0;
            if (res_valid && hold) held++;
            if (res_valid && rdy && !hold) done = 1'b1;
            @(posedge clk); #1;
        end
        op_valid = 1'b0; hold = 1'b0; rdy = 1'b1;
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: got no result expected latency %0d", name, lat);
        end
        check({name, "_latency"}, 32'(seen_lat), 32'(lat));
        check({name, "_stalls"}, 32'(stalls), 32'(lat));
    endtask

    initial begin
        int saw;
        rst = 1'b1; rdy = 1'b1; op_valid = 1'b0; flush = 1'b0; hold = 1'b0;
        funct = 3'd0; reg1 = 32'd0; reg2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue("mul",      MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, -1, 0);
        issue("mulhu",    MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, -1, 0);
        issue("mulh",     MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, -1, 0);
        issue("mulhsu",   MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_LAT, -1, 0);
        issue("div_zero", MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,       -1, 0);
        issue("remu_zero",MD_REMU,   32'd5,          32'd0,         32'd5,         1,       -1, 0);
        issue("div_ovf",  MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,       -1, 0);
        issue("rem_ovf",  MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,       -1, 0);
        issue("div_neg",  MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33,      -1, 0);
        issue("rem_neg",  MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33,      -1, 0);
        issue("divu",     MD_DIVU,   32'd100,        32'd7,         32'd14,        33,      -1, 0);
        issue("remu",     MD_REMU,   32'd100,        32'd7,         32'd2,         33,      -1, 0);
        issue("rdy_low",  MD_DIVU,   32'd100,        32'd7,         32'd14,        38,      10, 0);
        issue("hold3",    MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, -1, 3);
        @(posedge clk); #1;
        check("after_hold_idle", {31'd0, res_valid}, 32'd0);

        // Flush during BUSY: no result may ever appear for the aborted op
        op_valid = 1'b1; funct = MD_DIVU; reg1 = 32'd100; reg2 = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0;
        saw = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid) saw++;
            @(posedge clk); #1;
        end
        check("flush_no_result", 32'(saw), 32'd0);
        issue("divu_after_flush", MD_DIVU, 32'd9, 32'd3, 32'd3, 33, -1, 0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
